regfile_idex: RTL and testbench

- Decode-to-execute stage, directly downstream of the PC/ROM/IR fetch-decode path.
- Consumes the decoded RD/RS1/RS2 fields and the 32-bit instruction word, and reads two operands from a 32x32 register file.
- Captures operands, RD and instruction in an ID/EX pipeline register with stall/flush control.
- Accepts one write-back per cycle, with same-cycle write-through bypass to the read ports.

---
 rtl/riscv_pkg.sv | 14 +
 rtl/regfile_2r1w.sv | 65 ++++++
 rtl/regfile_idex.sv | 67 ++++++
 tb/tb_regfile_idex.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Constants and types for the RV32 datapath. Used by the IR, ID/EX and execute stages.
package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int NREGS  = 1 << REG_AW;

    typedef logic [REG_AW-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]   word_t;

    // addi x0,x0,0
    localparam word_t NOP_INSN = 32'h0000_0013;

endpackage : riscv_pkg

// File: rtl/regfile_2r1w.sv
// 32x32 register file with two combinational read ports and one write port.
// Reads bypass a same-cycle write. x0 is hardwired to zero.
// Defining REGFILE_DEBUG_EN adds a debug read port (dbg_addr/dbg_data) with no bypass.
module regfile_2r1w
    import riscv_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic [REG_AW-1:0]   rs1,
    input  logic [REG_AW-1:0]   rs2,
    input  logic                wb_en,
    input  logic [REG_AW-1:0]   wb_rd,
    input  logic [XLEN-1:0]     wb_data,
    output logic [XLEN-1:0]     rd1_data,
    output logic [XLEN-1:0]     rd2_data
`ifdef REGFILE_DEBUG_EN
    ,
    input  logic [REG_AW-1:0]   dbg_addr,
    output logic [XLEN-1:0]     dbg_data
`endif
);

    word_t mem [NREGS];
    logic  wr_hit;

    assign wr_hit = wb_en && (wb_rd != '0);

    // NOTE: the array is cleared on reset, so it is built from flops rather than
    // a RAM macro; a reset loop over a RAM would prevent memory inference.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                // NOTE: non-blocking assignment for all sequential state, so every
                // reader in this edge sees the pre-edge value.
                mem[i] <= '0;
            end
        end else if (wr_hit) begin
            mem[wb_rd] <= wb_data;
        end
    end

    // NOTE: outputs get a default before any condition, so no path leaves them
    // unassigned and no latch is inferred.
    always_comb begin
        rd1_data = '0;
        rd2_data = '0;
        if (rs1 != '0) begin
            rd1_data = (wr_hit && (wb_rd == rs1)) ? wb_data : mem[rs1];
        end
        if (rs2 != '0) begin
            rd2_data = (wr_hit && (wb_rd == rs2)) ? wb_data : mem[rs2];
        end
    end

`ifdef REGFILE_DEBUG_EN
    // Raw array view: no bypass, so it shows only what has been committed.
    always_comb begin
        dbg_data = '0;
        if (dbg_addr != '0) begin
            dbg_data = mem[dbg_addr];
        end
    end
`endif

endmodule : regfile_2r1w

// File: rtl/regfile_idex.sv
// Decode-to-execute stage: register-file read plus ID/EX pipeline register.
// Priority on each edge is reset > flush > stall > load. REGFILE_DEBUG_EN adds dbg_addr/dbg_data.
module regfile_idex
    import riscv_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic [REG_AW-1:0]   rs1,
    input  logic [REG_AW-1:0]   rs2,
    input  logic [REG_AW-1:0]   rd,
    input  logic [XLEN-1:0]     ins_in,
    input  logic                valid_in,
    input  logic                stall,
    input  logic                flush,
    input  logic                wb_en,
    input  logic [REG_AW-1:0]   wb_rd,
    input  logic [XLEN-1:0]     wb_data,
    output logic [XLEN-1:0]     rs1_data,
    output logic [XLEN-1:0]     rs2_data,
    output logic [REG_AW-1:0]   rd_ex,
    output logic [XLEN-1:0]     ins_ex,
    output logic                valid_ex
`ifdef REGFILE_DEBUG_EN
    ,
    input  logic [REG_AW-1:0]   dbg_addr,
    output logic [XLEN-1:0]     dbg_data
`endif
);

    word_t rd1_val;
    word_t rd2_val;

    regfile_2r1w u_rf (
        .clock    (clock),
        .reset    (reset),
        .rs1      (rs1),
        .rs2      (rs2),
        .wb_en    (wb_en),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .rd1_data (rd1_val),
        .rd2_data (rd2_val)
`ifdef REGFILE_DEBUG_EN
        ,
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
`endif
    );

    // A stalled entry keeps its operands; later write-backs do not refresh them.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            rs1_data <= '0;
            rs2_data <= '0;
            rd_ex    <= '0;
            ins_ex   <= NOP_INSN;
            valid_ex <= 1'b0;
        end else if (!stall) begin
            rs1_data <= rd1_val;
            rs2_data <= rd2_val;
            rd_ex    <= rd;
            ins_ex   <= ins_in;
            valid_ex <= valid_in;
        end
    end

endmodule : regfile_idex

// File: tb/tb_regfile_idex.sv
// Scoreboard bench for regfile_idex: the driver pushes hand-computed expectations,
// a negedge monitor pops and compares them against the ID/EX outputs.
module tb_regfile_idex;
    import riscv_pkg::*;

    typedef struct {
        logic        rst;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] ins;
        logic        vin;
        logic        stall;
        logic        flush;
        logic        wb_en;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic [4:0]  dbg;
    } stim_t;

    typedef struct {
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [4:0]  rd_ex;
        logic [31:0] ins_ex;
        logic        valid_ex;
        logic [31:0] dbg_data;
    } exp_t;

    localparam int NROWS = 21;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  rs1, rs2, rd, wb_rd, dbg_addr;
    logic [31:0] ins_in, wb_data;
    logic        valid_in, stall, flush, wb_en;
    logic [31:0] rs1_data, rs2_data, ins_ex, dbg_data;
    logic [4:0]  rd_ex;
    logic        valid_ex;

    int checks = 0;
    int errors = 0;

    exp_t  sb [$];
    stim_t stim_tbl [NROWS];
    exp_t  exp_tbl  [NROWS];

    always #5 clock = ~clock;

    regfile_idex dut (
        .clock    (clock),
        .reset    (reset),
        .rs1      (rs1),
        .rs2      (rs2),
        .rd       (rd),
        .ins_in   (ins_in),
        .valid_in (valid_in),
        .stall    (stall),
        .flush    (flush),
        .wb_en    (wb_en),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .rd_ex    (rd_ex),
        .ins_ex   (ins_ex),
        .valid_ex (valid_ex)
`ifdef REGFILE_DEBUG_EN
        ,
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
`endif
    );

`ifndef REGFILE_DEBUG_EN
    assign dbg_data = '0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply(input stim_t s);
        reset    = s.rst;
        rs1      = s.rs1;
        rs2      = s.rs2;
        rd       = s.rd;
        ins_in   = s.ins;
        valid_in = s.vin;
        stall    = s.stall;
        flush    = s.flush;
        wb_en    = s.wb_en;
        wb_rd    = s.wb_rd;
        wb_data  = s.wb_data;
        dbg_addr = s.dbg;
    endtask

    // Monitor: each posedge produces one result, checked at the following negedge.
    always @(negedge clock) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check("rs1_data", rs1_data, e.rs1_data);
            check("rs2_data", rs2_data, e.rs2_data);
            check("rd_ex",    {27'd0, rd_ex}, {27'd0, e.rd_ex});
            check("ins_ex",   ins_ex, e.ins_ex);
            check("valid_ex", {31'd0, valid_ex}, {31'd0, e.valid_ex});
`ifdef REGFILE_DEBUG_EN
            check("dbg_data", dbg_data, e.dbg_data);
`endif
        end
    end

    initial begin
        exp_t bubble;
        bubble = '{32'h0, 32'h0, 5'd0, NOP_INSN, 1'b0, 32'h0};

        // rst rs1 rs2 rd ins vin stall flush wb_en wb_rd wb_data dbg
        // Reset two cycles with a pending x5 write that must be discarded.
        stim_tbl[0]  = '{1, 5, 0, 3, 32'hFFFF_FFFF, 1, 0, 0, 1, 5, 32'h0000_DEAD, 0};
        exp_tbl[0]   = bubble;
        stim_tbl[1]  = stim_tbl[0];
        exp_tbl[1]   = bubble;
        stim_tbl[2]  = '{0, 5, 0, 2, 32'h0000_0033, 1, 0, 0, 0, 0, 32'h0, 0};
        exp_tbl[2]   = '{32'h0, 32'h0, 2, 32'h0000_0033, 1, 32'h0};
        // Write x3, read it next cycle.
        stim_tbl[3]  = '{0, 0, 0, 4, 32'h0010_0113, 1, 0, 0, 1, 3, 32'h1234_5678, 0};
        exp_tbl[3]   = '{32'h0, 32'h0, 4, 32'h0010_0113, 1, 32'h0};
        stim_tbl[4]  = '{0, 3, 0, 5, 32'h0020_81B3, 1, 0, 0, 0, 0, 32'h0, 0};
        exp_tbl[4]   = '{32'h1234_5678, 32'h0, 5, 32'h0020_81B3, 1, 32'h0};
        // Both ports bypass the same x7 write.
        stim_tbl[5]  = '{0, 7, 7, 8, 32'h0073_8433, 1, 0, 0, 1, 7, 32'hA5A5_A5A5, 0};
        exp_tbl[5]   = '{32'hA5A5_A5A5, 32'hA5A5_A5A5, 8, 32'h0073_8433, 1, 32'h0};
        // Write to x0 must neither bypass nor commit.
        stim_tbl[6]  = '{0, 0, 7, 9, 32'h0000_0293, 1, 0, 0, 1, 0, 32'hFFFF_FFFF, 0};
        exp_tbl[6]   = '{32'h0, 32'hA5A5_A5A5, 9, 32'h0000_0293, 1, 32'h0};
        stim_tbl[7]  = '{0, 0, 3, 10, 32'h0030_0513, 1, 0, 0, 0, 0, 32'h0, 0};
        exp_tbl[7]   = '{32'h0, 32'h1234_5678, 10, 32'h0030_0513, 1, 32'h0};
        // valid_in low: data loaded, valid_ex low.
        stim_tbl[8]  = '{0, 3, 7, 11, 32'h2222_2222, 0, 0, 0, 0, 0, 32'h0, 0};
        exp_tbl[8]   = '{32'h1234_5678, 32'hA5A5_A5A5, 11, 32'h2222_2222, 0, 32'h0};
        // Load, then stall three cycles with changing inputs and an x9 write.
        stim_tbl[9]  = '{0, 3, 7, 1, 32'h0050_0093, 1, 0, 0, 0, 0, 32'h0, 0};
        exp_tbl[9]   = '{32'h1234_5678, 32'hA5A5_A5A5, 1, 32'h0050_0093, 1, 32'h0};
        stim_tbl[10] = '{0, 7, 3, 2, 32'hAAAA_0000, 0, 1, 0, 1, 9, 32'h0000_0099, 0};
        exp_tbl[10]  = exp_tbl[9];
        stim_tbl[11] = '{0, 9, 9, 3, 32'hBBBB_0000, 1, 1, 0, 0, 0, 32'h0, 0};
        exp_tbl[11]  = exp_tbl[9];
        stim_tbl[12] = '{0, 0, 9, 13, 32'hCCCC_0000, 1, 1, 0, 0, 0, 32'h0, 0};
        exp_tbl[12]  = exp_tbl[9];
        stim_tbl[13] = '{0, 9, 0, 6, 32'h0090_0313, 1, 0, 0, 0, 0, 32'h0, 0};
        exp_tbl[13]  = '{32'h0000_0099, 32'h0, 6, 32'h0090_0313, 1, 32'h0};
        // Flush beats stall; the concurrent x4 write still commits.
        stim_tbl[14] = '{0, 3, 7, 7, 32'h0041_8633, 1, 1, 1, 1, 4, 32'h0000_0011, 0};
        exp_tbl[14]  = bubble;
        stim_tbl[15] = '{0, 4, 3, 12, 32'h0041_8633, 1, 0, 0, 0, 0, 32'h0, 0};
        exp_tbl[15]  = '{32'h0000_0011, 32'h1234_5678, 12, 32'h0041_8633, 1, 32'h0};
        stim_tbl[16] = '{0, 3, 3, 14, 32'h0031_8733, 1, 0, 1, 0, 0, 32'h0, 0};
        exp_tbl[16]  = bubble;
        // Reset beats flush/stall, discards the x3 write and clears the array.
        stim_tbl[17] = '{1, 3, 4, 15, 32'h0032_07B3, 1, 1, 1, 1, 3, 32'h0000_0077, 0};
        exp_tbl[17]  = bubble;
        stim_tbl[18] = '{0, 3, 4, 16, 32'h0041_8833, 1, 0, 0, 0, 0, 32'h0, 0};
        exp_tbl[18]  = '{32'h0, 32'h0, 16, 32'h0041_8833, 1, 32'h0};
        // x31 write observed through the debug port, then x0 on the debug port.
        stim_tbl[19] = '{0, 0, 0, 0, NOP_INSN, 0, 0, 0, 1, 31, 32'hCAFE_F00D, 31};
        exp_tbl[19]  = '{32'h0, 32'h0, 0, NOP_INSN, 0, 32'hCAFE_F00D};
        stim_tbl[20] = '{0, 31, 0, 17, 32'h01F0_08B3, 1, 0, 0, 0, 0, 32'h0, 0};
        exp_tbl[20]  = '{32'hCAFE_F00D, 32'h0, 17, 32'h01F0_08B3, 1, 32'h0};

        apply('{0, 0, 0, 0, NOP_INSN, 0, 0, 0, 0, 0, 32'h0, 0});

        for (int i = 0; i < NROWS; i++) begin
            @(negedge clock);
            #1;
            apply(stim_tbl[i]);
            sb.push_back(exp_tbl[i]);
        end

        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            @(posedge clock);
        end
        @(negedge clock);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_regfile_idex
